// File: rtl/qr_osif_tx_pkg.sv
// Shared constants for the QR transmit path: serializer state codes, strobe and
// trailer field widths.
package qr_osif_tx_pkg;

    localparam logic [1:0] ST_LO  = 2'd0;
    localparam logic [1:0] ST_HI  = 2'd1;
    localparam logic [1:0] ST_TRL = 2'd2;

    localparam logic [3:0] STRB_ALL = 4'hF;

    localparam int SEXT_W      = 16;
    localparam int TRAILER_PAD = 15;
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/qr_beat_fifo.sv
// Beat FIFO absorbing QR_CORDIC rows; full/empty come from an extra pointer wrap bit.
// A push on a full FIFO is accepted when a pop frees the slot in the same cycle.
module qr_beat_fifo
    import qr_osif_tx_pkg::*;
#(
    parameter int WIDTH = 52,
    parameter int DEPTH = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_drop  = i_push & w_full & ~w_do_pop;

endmodule

// File: rtl/qr_osif_tx.sv
// qr_osif_tx: unpacks QR_CORDIC result rows into framed 32-bit stream words (lo, hi).
// Define QR_TX_TRAILER_EN to append a per-frame trailer word carrying ovf_err and frame count.
module qr_osif_tx
    import qr_osif_tx_pkg::*;
#(
    parameter int DATA_LENGTH = 13,
    parameter int ROWS        = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TBITS       = 32,
    parameter int TBYTE       = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     qr_valid,
    input  logic [DATA_LENGTH*4-1:0] qr_data,
    output logic [TBITS-1:0]         osif_data_din,
    output logic [TBYTE-1:0]         osif_strb_din,
    output logic                     osif_last_din,
    output logic                     osif_user_din,
    input  logic                     osif_full_n,
    output logic                     osif_write,
    output logic                     ovf_err,
    output logic                     busy
);

    localparam int              WORDS     = 2 * ROWS;
    localparam int              WCW       = $clog2(WORDS);
    localparam logic [WCW-1:0]  LAST_WORD = WCW'(WORDS - 1);

    logic [DATA_LENGTH*4-1:0] w_head;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_drop;
    logic                     w_not_empty;
    logic                     w_write;
    logic                     w_pop;
    logic [SEXT_W-1:0]        w_ext [4];
    logic [TBITS-1:0]         w_lo;
    logic [TBITS-1:0]         w_hi;
    logic [WCW-1:0]           w_wcnt_inc;
    logic [1:0]               r_state;
    logic [WCW-1:0]           r_wcnt;
    logic                     r_ovf;
`ifdef QR_TX_TRAILER_EN
    logic [FRAME_CNT_W-1:0]   r_frame_cnt;
`endif

    qr_beat_fifo #(
        .WIDTH (DATA_LENGTH*4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (qr_valid),
        .i_data  (qr_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    for (genvar k = 0; k < 4; k++) begin : g_ext
        assign w_ext[k] = SEXT_W'($signed(w_head[k*DATA_LENGTH +: DATA_LENGTH]));
    end

    assign w_lo        = {w_ext[1], w_ext[0]};
    assign w_hi        = {w_ext[3], w_ext[2]};
    assign w_not_empty = ~w_empty;
    assign w_wcnt_inc  = (r_wcnt == LAST_WORD) ? '0 : r_wcnt + WCW'(1);

`ifdef QR_TX_TRAILER_EN
    // The trailer is sent from no FIFO entry, so only downstream room gates it.
    assign w_write = (r_state == ST_TRL) ? osif_full_n : (w_not_empty & osif_full_n);
`else
    assign w_write = w_not_empty & osif_full_n;
`endif
    assign w_pop = w_write & (r_state == ST_HI);

    always_comb begin
        osif_data_din = '0;
        osif_strb_din = '0;
        osif_user_din = 1'b0;
        osif_last_din = 1'b0;
`ifdef QR_TX_TRAILER_EN
        if (r_state == ST_TRL) begin
            osif_data_din = {r_ovf, TRAILER_PAD'(0), r_frame_cnt};
            osif_strb_din = STRB_ALL;
            osif_last_din = 1'b1;
        end else if (w_not_empty) begin
            osif_data_din = (r_state == ST_HI) ? w_hi : w_lo;
            osif_strb_din = STRB_ALL;
            osif_user_din = (r_wcnt == '0);
        end
`else
        if (w_not_empty) begin
            osif_data_din = (r_state == ST_HI) ? w_hi : w_lo;
            osif_strb_din = STRB_ALL;
            osif_user_din = (r_wcnt == '0);
            osif_last_din = (r_wcnt == LAST_WORD);
        end
`endif
    end

    // In trailer builds the word counter parks on the last data word while in TRL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LO;
            r_wcnt  <= '0;
        end else if (w_write) begin
            case (r_state)
                ST_LO: begin
                    r_state <= ST_HI;
                    r_wcnt  <= w_wcnt_inc;
                end
                ST_HI: begin
`ifdef QR_TX_TRAILER_EN
                    if (r_wcnt == LAST_WORD) begin
                        r_state <= ST_TRL;
                    end else begin
                        r_state <= ST_LO;
                        r_wcnt  <= w_wcnt_inc;
                    end
`else
                    r_state <= ST_LO;
                    r_wcnt  <= w_wcnt_inc;
`endif
                end
`ifdef QR_TX_TRAILER_EN
                ST_TRL: begin
                    r_state <= ST_LO;
                    r_wcnt  <= '0;
                end
`endif
                default: r_state <= ST_LO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
    end

`ifdef QR_TX_TRAILER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_frame_cnt <= '0;
        else if (w_write && r_state == ST_TRL)  r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
`endif

    assign osif_write = w_write;
    assign ovf_err    = r_ovf;
    assign busy       = w_not_empty | (r_wcnt != '0);

endmodule

// File: tb/tb_qr_osif_tx.sv
// Scoreboard bench for qr_osif_tx: stimulus enqueues expected words, a negedge monitor
// pops and compares every written word. Trailer expectations follow QR_TX_TRAILER_EN.
module tb_qr_osif_tx;

    localparam int DL    = 13;
    localparam int ROWS  = 8;
    localparam int DEPTH = 8;
    localparam int ROW_W = 4 * DL;
    localparam int WORDS = 2 * ROWS;
`ifdef QR_TX_TRAILER_EN
    localparam int FRAME_WORDS = WORDS + 1;
`else
    localparam int FRAME_WORDS = WORDS;
`endif

    typedef struct {
        logic [31:0] data;
        bit          user;
        bit          last;
        bit          isTrailer;
    } expWord_t;

    logic             clk;
    logic             rst_n;
    logic             qr_valid;
    logic [ROW_W-1:0] qr_data;
    logic [31:0]      osif_data_din;
    logic [3:0]       osif_strb_din;
    logic             osif_last_din;
    logic             osif_user_din;
    logic             osif_full_n;
    logic             osif_write;
    logic             ovf_err;
    logic             busy;

    expWord_t expQ[$];
    int       vecs;
    int       misses;
    int       cycleCnt;
    int       wordsSeen;
    int       prevWriteCycle;
    int       lastWriteCycle;
    int       modelIdx;
    int       modelFrame;
    bit       modelOvf;
    bit       trackOcc;
    int       occCount;

    qr_osif_tx #(
        .DATA_LENGTH (DL),
        .ROWS        (ROWS),
        .FIFO_DEPTH  (DEPTH),
        .TBITS       (32),
        .TBYTE       (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .qr_valid      (qr_valid),
        .qr_data       (qr_data),
        .osif_data_din (osif_data_din),
        .osif_strb_din (osif_strb_din),
        .osif_last_din (osif_last_din),
        .osif_user_din (osif_user_din),
        .osif_full_n   (osif_full_n),
        .osif_write    (osif_write),
        .ovf_err       (ovf_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecs++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        vecs++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Reference packing: interpret each element as a two's-complement integer.
    function automatic logic [15:0] sext16(input logic [DL-1:0] el);
        int v;
        v = int'(el);
        if (v >= (1 << (DL - 1))) v = v - (1 << DL);
        return 16'(v);
    endfunction

    function automatic logic [31:0] packWord(input logic [ROW_W-1:0] row, input int half);
        logic [DL-1:0] a;
        logic [DL-1:0] b;
        a = row[(2*half)*DL +: DL];
        b = row[(2*half+1)*DL +: DL];
        return {sext16(b), sext16(a)};
    endfunction

    function automatic logic [31:0] trailerWord();
        return {modelOvf, 15'd0, 16'(modelFrame)};
    endfunction

    function automatic logic [ROW_W-1:0] randRow();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[ROW_W-1:0];
    endfunction

    task automatic enqueueBeat(input logic [ROW_W-1:0] row);
        for (int half = 0; half < 2; half++) begin
            expWord_t e;
            e.data      = packWord(row, half);
            e.user      = (modelIdx == 0);
`ifdef QR_TX_TRAILER_EN
            e.last      = 1'b0;
`else
            e.last      = (modelIdx == WORDS - 1);
`endif
            e.isTrailer = 1'b0;
            expQ.push_back(e);
            modelIdx++;
            if (modelIdx == WORDS) begin
                modelIdx = 0;
`ifdef QR_TX_TRAILER_EN
                e.data      = 32'h0;
                e.user      = 1'b0;
                e.last      = 1'b1;
                e.isTrailer = 1'b1;
                expQ.push_back(e);
`endif
            end
        end
    endtask

    // Drives one beat for one cycle; called and returns 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [ROW_W-1:0] row);
        qr_valid = 1'b1;
        qr_data  = row;
        if (trackOcc && occCount >= DEPTH) begin
            modelOvf = 1'b1;
        end else begin
            if (trackOcc) occCount++;
            enqueueBeat(row);
        end
        @(posedge clk);
        #1;
        qr_valid = 1'b0;
    endtask

    task automatic clearModel();
        expQ.delete();
        modelIdx   = 0;
        modelFrame = 0;
        modelOvf   = 1'b0;
        occCount   = 0;
    endtask

    task automatic resetDut();
        rst_n    = 1'b0;
        qr_valid = 1'b0;
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic waitDrain(input string name, input int maxCycles);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        expWord_t    e;
        logic [31:0] ed;
        if (rst_n && osif_write) begin
            wordsSeen++;
            prevWriteCycle = lastWriteCycle;
            lastWriteCycle = cycleCnt;
            if (expQ.size() == 0) begin
                checkBit("unexpected_write", osif_write, 1'b0);
            end else begin
                e  = expQ.pop_front();
                ed = e.isTrailer ? trailerWord() : e.data;
                if (e.isTrailer) modelFrame++;
                checkOutput("word_data", osif_data_din, ed);
                checkBit("word_user", osif_user_din, e.user);
                checkBit("word_last", osif_last_din, e.last);
                checkOutput("word_strb", 32'(osif_strb_din), 32'hF);
            end
        end else if (rst_n && osif_strb_din != 4'h0 && expQ.size() != 0) begin
            e = expQ[0];
            checkOutput("held_data", osif_data_din, e.isTrailer ? trailerWord() : e.data);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [ROW_W-1:0] row;
        int               n;
        int               pushed;
        int               base;

        vecs = 0; misses = 0; cycleCnt = 0; wordsSeen = 0;
        prevWriteCycle = 0; lastWriteCycle = 0; trackOcc = 1'b0;
        rst_n = 1'b0; qr_valid = 1'b0; qr_data = '0; osif_full_n = 1'b1;
        clearModel();

        repeat (2) @(posedge clk);
        #1;
        checkBit("rst_write", osif_write, 1'b0);
        checkBit("rst_ovf", ovf_err, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkOutput("rst_data", osif_data_din, 32'h0);
        checkOutput("rst_strb", 32'(osif_strb_din), 32'h0);
        checkBit("rst_user", osif_user_din, 1'b0);
        checkBit("rst_last", osif_last_din, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkBit("idle_write", osif_write, 1'b0);
        checkBit("idle_busy", busy, 1'b0);

        $display("[TB] single beat packing");
        resetDut();
        row = {13'h1000, 13'h0FFF, 13'h1FFF, 13'h0001};
        applyStimulus(row);
        @(negedge clk);
        checkOutput("single_word0", osif_data_din, 32'hFFFF_0001);
        checkBit("single_user0", osif_user_din, 1'b1);
        checkBit("single_write0", osif_write, 1'b1);
        @(negedge clk);
        checkOutput("single_word1", osif_data_din, 32'hF000_0FFF);
        checkBit("single_user1", osif_user_din, 1'b0);
        checkBit("single_write1", osif_write, 1'b1);
        @(negedge clk);
        checkBit("single_write_done", osif_write, 1'b0);
        checkBit("single_busy_midframe", busy, 1'b1);
        checkOutput("single_consecutive", 32'(lastWriteCycle - prevWriteCycle), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] back-to-back frames");
        resetDut();
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < ROWS; b++) applyStimulus(randRow());
            waitDrain("frame_drain", 200);
            @(negedge clk);
            checkBit("frame_busy_after", busy, 1'b0);
            checkBit("frame_write_after", osif_write, 1'b0);
            @(posedge clk);
            #1;
        end

        $display("[TB] full_n toggling");
        resetDut();
        pushed = 0;
        n = 0;
        while ((pushed < ROWS || expQ.size() != 0) && n < 2000) begin
            osif_full_n = ~osif_full_n;
            if (pushed < ROWS && expQ.size() <= 2*DEPTH - 4 && $urandom_range(1, 0) == 1) begin
                applyStimulus(randRow());
                pushed++;
            end else begin
                @(posedge clk);
                #1;
            end
            n++;
        end
        checkOutput("toggle_drain", 32'(expQ.size()), 32'd0);
        osif_full_n = 1'b1;

        $display("[TB] random traffic");
        pushed = 0;
        n = 0;
        while (pushed < 5*ROWS && n < 5000) begin
            osif_full_n = ($urandom_range(3, 0) != 0);
            if (expQ.size() <= 2*DEPTH - 4 && $urandom_range(1, 0) == 1) begin
                applyStimulus(randRow());
                pushed++;
            end else begin
                @(posedge clk);
                #1;
            end
            n++;
        end
        osif_full_n = 1'b1;
        waitDrain("random_drain", 500);

        $display("[TB] overflow with full_n held low");
        resetDut();
        osif_full_n = 1'b0;
        trackOcc    = 1'b1;
        for (int b = 0; b < DEPTH + 1; b++) applyStimulus(randRow());
        trackOcc = 1'b0;
        @(negedge clk);
        checkBit("ovf_set", ovf_err, 1'b1);
        checkBit("ovf_busy", busy, 1'b1);
        checkBit("ovf_no_write", osif_write, 1'b0);
        @(posedge clk);
        #1;
        base = wordsSeen;
        osif_full_n = 1'b1;
        waitDrain("ovf_drain", 200);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("ovf_word_count", 32'(wordsSeen - base), 32'(FRAME_WORDS));
        checkBit("ovf_sticky", ovf_err, 1'b1);

        $display("[TB] reset mid-frame");
        resetDut();
        checkBit("reset_clears_ovf", ovf_err, 1'b0);
        base = wordsSeen;
        for (int b = 0; b < 4; b++) applyStimulus(randRow());
        n = 0;
        while (wordsSeen - base < 6 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("pre_reset_words", 32'(wordsSeen - base), 32'd6);
        rst_n = 1'b0;
        clearModel();
        #1;
        checkBit("mid_rst_write", osif_write, 1'b0);
        checkBit("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_data", osif_data_din, 32'h0);
        checkOutput("mid_rst_strb", 32'(osif_strb_din), 32'h0);
        checkBit("mid_rst_user", osif_user_din, 1'b0);
        checkBit("mid_rst_last", osif_last_din, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(randRow());
        @(negedge clk);
        checkBit("post_rst_user", osif_user_din, 1'b1);
        @(posedge clk);
        #1;
        waitDrain("post_rst_drain", 50);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
        $finish;
    end

endmodule

// File: doc/qr_osif_tx.md
Name: qr_osif_tx

Overview:
- Transmit end of the QR engine datapath: accepts result beats from QR_CORDIC and serialises them onto the 32-bit output stream FIFO interface (osif_*), with strobe/last/user framing.
- QR_CORDIC has no backpressure, so beats are absorbed in an internal beat FIFO and drained at the rate allowed by osif_full_n.
- Mirror of the input-side reader: the reader packs stream words into wide matrix rows; this block unpacks wide rows into stream words.

Parameters:
- DATA_LENGTH, 13, width of one signed matrix element; legal range 2..16.
- ROWS, 8, beats per matrix frame (one beat = one row of 4 elements).
- FIFO_DEPTH, 8, beat FIFO depth; power of two, at least 2.
- TBITS, 32, stream data width; fixed at 32.
- TBYTE, 4, stream strobe width; fixed at 4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- qr_valid  in  1  one-cycle strobe; qr_data holds a valid row.
- qr_data  in  DATA_LENGTH*4  row; element k = qr_data[k*DATA_LENGTH +: DATA_LENGTH], k=0..3.
- osif_data_din  out  TBITS  stream word.
- osif_strb_din  out  TBYTE  byte strobes.
- osif_last_din  out  1  last word of frame.
- osif_user_din  out  1  first word of frame.
- osif_full_n  in  1  downstream FIFO has room.
- osif_write  out  1  word transferred this cycle.
- ovf_err  out  1  sticky: a beat was dropped on FIFO full.
- busy  out  1  FIFO not empty or a frame is partially sent.

Behaviour:
- Reset values: osif_write=0, ovf_err=0, busy=0. osif_data_din=0, strb=0, last=0, user=0 while the FIFO is empty. Reset mid-frame discards all FIFO contents and counters; the next word sent after reset carries user=1.
- Packing: each beat produces two words, lo then hi.
  - word lo = {sext16(e1), sext16(e0)}.
  - word hi = {sext16(e3), sext16(e2)}.
  - sext16 sign-extends DATA_LENGTH to 16 bits.
- osif_strb_din = 4'hF whenever the FIFO is non-empty.
- Beat FIFO:
  - Write when qr_valid=1 and the FIFO is not full.
  - qr_valid while full: beat dropped, ovf_err set (cleared only by reset), frame counters not advanced.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are derived from an extra wrap bit.
- Serializer FSM (HALF register): states LO, HI.
  - osif_write = fifo_not_empty & osif_full_n (combinational).
  - LO: on write, go to HI.
  - HI: on write, pop the FIFO and go to LO.
  - No write: hold state and outputs.
- Word counter: 0..2*ROWS-1.
  - osif_user_din=1 when word counter=0.
  - osif_last_din=1 when word counter=2*ROWS-1.
  - Increments on each write; wraps to 0 after last.
- Latency: a beat written at edge t is presentable in the cycle after edge t. With full_n held at 1, the first write occurs in that cycle. Sustained rate is 1 word/cycle, i.e. 2 cycles per beat.
- Simultaneous push and pop on a full FIFO: the pop frees the slot in the same cycle, so the push is accepted and there is no overflow.
- Simultaneous push and pop on an empty FIFO cannot occur, because a pop requires a non-empty FIFO.
- busy = fifo_not_empty | (word counter != 0).

Optional Feature:
- Macro QR_TX_TRAILER_EN.
- Defined: after word 2*ROWS-1, a trailer word is sent = {ovf_err, 15'd0, frame_cnt[15:0]}.
  - last moves from data word 2*ROWS-1 to the trailer.
  - frame_cnt starts at 0 and increments after each trailer write, wrapping at 16 bits.
  - The FSM gains a TRL state, entered from HI on the final write; the pop happens on entering TRL.
  - In TRL, osif_write = osif_full_n regardless of FIFO state.
- Undefined: no trailer, no frame_cnt; behaviour exactly as above.

Decomposition:
- Shared package: state encodings (LO, HI, TRL), STRB_ALL=4'hF, sext helper width constants, TRAILER_PAD width.
- One sub-module: qr_beat_fifo (parameterised width DATA_LENGTH*4, depth FIFO_DEPTH; push/pop/full/empty/head).
- Serializer, framing counters and trailer logic stay in qr_osif_tx.

Test Plan:
- Single beat, e0=1, e1=-1 (13'h1FFF), e2=0x0FFF, e3=0x1000, full_n=1. Expect:
  - word0=32'hFFFF_0001, user=1.
  - word1=32'hF000_0FFF.
  - writes in consecutive cycles.
- 8 back-to-back beats with full_n=1: 16 writes; user only on word 0, last only on word 15; busy falls the cycle after word 15.
- Toggle full_n every cycle during a frame: no word duplicated or skipped; data held stable while full_n=0.
- full_n=0 held, 9 beats pushed: first 8 stored; 9th dropped, ovf_err=1. Release: exactly 16 words out.
- Assert rst_n low after word 5 of a frame: outputs go to reset values immediately. New frame after release starts with user=1 and counter 0.
- With QR_TX_TRAILER_EN, two frames: word 16 = 32'h0000_0000 with last=1; second trailer = 32'h0000_0001.
